// File: rtl/port_b_stream_reader.sv
// Port-B read engine: walks LENGTH words from BASE_ADDR over the RAM read port and
// replays them in order as a valid/ready stream through a small credit-limited FIFO.

module port_b_stream_reader #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 24,
  parameter int BASE_ADDR  = 0,
  parameter int LENGTH     = 90000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_b,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] read_data_b,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (LENGTH < 1) begin : g_bad_length
    $error("port_b_stream_reader: LENGTH must be at least 1");
  end
  if ((longint'(BASE_ADDR) + longint'(LENGTH) - 1) >= (longint'(1) << ADDR_WIDTH)) begin : g_bad_range
    $error("port_b_stream_reader: BASE_ADDR+LENGTH-1 does not fit ADDR_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("port_b_stream_reader: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      accept_cnt;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_count;

  logic launch;
  logic issue;
  logic last_issue;
  logic push;
  logic pop;
  logic last_accept;

  // A read is only launched when its word is guaranteed a FIFO slot, counting the
  // read still in flight, so the capture path never needs back-pressure.
  always_comb begin
    launch      = 1'b0;
    issue       = 1'b0;
    last_issue  = 1'b0;
    push        = rd_pending;
    pop         = out_valid && out_ready;
    last_accept = 1'b0;
    if (state == ST_IDLE) begin
      launch = start;
    end
    if (state == ST_ISSUE) begin
      issue = (int'(fifo_count) + int'(rd_pending)) < FIFO_DEPTH;
    end
    last_issue  = issue && (issue_cnt == CNT_W'(LENGTH - 1));
    last_accept = pop && (accept_cnt == CNT_W'(LENGTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)       state_next = ST_ISSUE;
      ST_ISSUE: if (last_issue)  state_next = ST_DRAIN;
      ST_DRAIN: if (last_accept) state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_b or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_b or posedge reset) begin
    if (reset) begin
      issue_cnt  <= '0;
      accept_cnt <= '0;
      address_b  <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (launch) begin
        issue_cnt  <= '0;
        accept_cnt <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          address_b <= ADDR_WIDTH'(BASE_ADDR + int'(issue_cnt));
        end
        if (pop) begin
          accept_cnt <= accept_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Skid FIFO: the head slot is never written while it is visible, so out_data is
  // stable whenever the consumer stalls.
  always_ff @(posedge clk_b or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= read_data_b;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_b) begin
    if (!reset) begin
      assert (!(push && fifo_count[PTR_W]));
    end
  end

  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule
